execute_issue_stage: RTL and testbench

- ID/EX pipeline register that feeds the ALU directly: captures decoded operands and control from decode and drives ALU A, B and ctrl for the execute stage.
- Resolves data hazards: forwards results from MEM and WB into the registered operands and detects load-use hazards.
- Handles downstream hold, branch flush and bubble insertion, so the ALU itself stays purely combinational.

---
 rtl/execute_issue_stage_pkg.sv | 26 ++
 rtl/execute_issue_stage_operand_forward_mux.sv | 37 +++
 rtl/execute_issue_stage.sv | 202 ++++++++++++++++++++
 tb/tb_execute_issue_stage.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_issue_stage_pkg.sv
// Shared constants for the execute issue stage: ALU operation codes and default widths.
package execute_issue_stage_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_AW_DEF = 5;
  localparam int SHAMT_W    = 5;
  localparam int ALU_CTRL_W = 4;

  // aluDisabled marks a bubble so the ALU result is never mistaken for real work.
  typedef enum logic [ALU_CTRL_W-1:0] {
    aluAdd          = 4'h0,
    aluSub          = 4'h1,
    aluAnd          = 4'h2,
    aluOr           = 4'h3,
    aluXor          = 4'h4,
    aluNor          = 4'h5,
    aluSlt          = 4'h6,
    aluSltu         = 4'h7,
    aluShiftLeft    = 4'h8,
    aluShiftRightL  = 4'h9,
    aluShiftRightA  = 4'hA,
    aluLui          = 4'hB,
    aluDisabled     = 4'hF
  } alu_op_e;

endpackage

// File: rtl/execute_issue_stage_operand_forward_mux.sv
// Combinational forward select for one source register: MEM beats WB beats register file.
module operand_forward_mux
  import execute_issue_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] src_addr_i,
  input  logic [DATA_W-1:0] rf_data_i,
  input  logic              mem_reg_write_i,
  input  logic [REG_AW-1:0] mem_dest_addr_i,
  input  logic [DATA_W-1:0] mem_result_i,
  input  logic              wb_reg_write_i,
  input  logic [REG_AW-1:0] wb_dest_addr_i,
  input  logic [DATA_W-1:0] wb_result_i,
  output logic [DATA_W-1:0] fwd_data_o
);

  logic src_nonzero;
  logic mem_hit;
  logic wb_hit;

  // Register 0 never forwards, so it always reads the hard-wired zero from the file.
  assign src_nonzero = (src_addr_i != '0);
  assign mem_hit     = src_nonzero && mem_reg_write_i && (mem_dest_addr_i == src_addr_i);
  assign wb_hit      = src_nonzero && wb_reg_write_i && (wb_dest_addr_i == src_addr_i);

  always_comb begin
    fwd_data_o = rf_data_i;
    if (mem_hit) begin
      fwd_data_o = mem_result_i;
    end else if (wb_hit) begin
      fwd_data_o = wb_result_i;
    end
  end

endmodule

// File: rtl/execute_issue_stage.sv
// ID/EX pipeline register feeding the ALU: forwarding, load-use detection, hold, flush and bubbles.
module execute_issue_stage
  import execute_issue_stage_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_AW = REG_AW_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [REG_AW-1:0]     id_rs_addr,
  input  logic [REG_AW-1:0]     id_rt_addr,
  input  logic                  id_rs_used,
  input  logic                  id_rt_used,
  input  logic [DATA_W-1:0]     id_rs_data,
  input  logic [DATA_W-1:0]     id_rt_data,
  input  logic [DATA_W-1:0]     id_imm32,
  input  logic [SHAMT_W-1:0]    id_shamt,
  input  logic                  id_use_imm,
  input  logic                  id_use_shamt,
  input  logic [ALU_CTRL_W-1:0] id_alu_ctrl,
  input  logic [REG_AW-1:0]     id_dest_addr,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  hold,
  input  logic                  flush,
  input  logic                  mem_reg_write,
  input  logic [REG_AW-1:0]     mem_dest_addr,
  input  logic [DATA_W-1:0]     mem_result,
  input  logic                  wb_reg_write,
  input  logic [REG_AW-1:0]     wb_dest_addr,
  input  logic [DATA_W-1:0]     wb_result,
  output logic [DATA_W-1:0]     alu_a,
  output logic [DATA_W-1:0]     alu_b,
  output logic [ALU_CTRL_W-1:0] alu_ctrl,
  output logic                  ex_valid,
  output logic [REG_AW-1:0]     ex_dest_addr,
  output logic                  ex_reg_write,
  output logic                  ex_mem_read,
  output logic [DATA_W-1:0]     ex_store_data,
  output logic                  hazard_stall
);

  // Flow control: flush beats hold; hold freezes the stage (operands still refresh from
  // forwarding); hazard_stall asks decode to re-present the same instruction next cycle.
  logic                  valid_q,     valid_d;
  logic [REG_AW-1:0]     rs_addr_q,   rs_addr_d;
  logic [REG_AW-1:0]     rt_addr_q,   rt_addr_d;
  logic [DATA_W-1:0]     rs_val_q,    rs_val_d;
  logic [DATA_W-1:0]     rt_val_q,    rt_val_d;
  logic [DATA_W-1:0]     imm_q,       imm_d;
  logic [SHAMT_W-1:0]    shamt_q,     shamt_d;
  logic                  use_imm_q,   use_imm_d;
  logic                  use_shamt_q, use_shamt_d;
  logic [ALU_CTRL_W-1:0] ctrl_q,      ctrl_d;
  logic [REG_AW-1:0]     dest_q,      dest_d;
  logic                  reg_write_q, reg_write_d;
  logic                  mem_read_q,  mem_read_d;

  logic [REG_AW-1:0] rs_src_addr, rt_src_addr;
  logic [DATA_W-1:0] rs_src_data, rt_src_data;
  logic [DATA_W-1:0] rs_fwd, rt_fwd;
  logic              rs_hit, rt_hit;
  logic              load_bubble;

  // While holding, the muxes re-forward the EX instruction's own sources.
  assign rs_src_addr = hold ? rs_addr_q : id_rs_addr;
  assign rt_src_addr = hold ? rt_addr_q : id_rt_addr;
  assign rs_src_data = hold ? rs_val_q  : id_rs_data;
  assign rt_src_data = hold ? rt_val_q  : id_rt_data;

  operand_forward_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rs_fwd (
    .src_addr_i      (rs_src_addr),
    .rf_data_i       (rs_src_data),
    .mem_reg_write_i (mem_reg_write),
    .mem_dest_addr_i (mem_dest_addr),
    .mem_result_i    (mem_result),
    .wb_reg_write_i  (wb_reg_write),
    .wb_dest_addr_i  (wb_dest_addr),
    .wb_result_i     (wb_result),
    .fwd_data_o      (rs_fwd)
  );

  operand_forward_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_rt_fwd (
    .src_addr_i      (rt_src_addr),
    .rf_data_i       (rt_src_data),
    .mem_reg_write_i (mem_reg_write),
    .mem_dest_addr_i (mem_dest_addr),
    .mem_result_i    (mem_result),
    .wb_reg_write_i  (wb_reg_write),
    .wb_dest_addr_i  (wb_dest_addr),
    .wb_result_i     (wb_result),
    .fwd_data_o      (rt_fwd)
  );

  assign rs_hit       = id_rs_used && (id_rs_addr == dest_q);
  assign rt_hit       = id_rt_used && (id_rt_addr == dest_q);
  assign hazard_stall = valid_q && mem_read_q && (dest_q != '0) && id_valid &&
                        (rs_hit || rt_hit) && !hold && !flush;

  // An invalid decode slot is loaded as a bubble so every ex_* output reads zero.
  assign load_bubble = flush || (!hold && (hazard_stall || !id_valid));

  always_comb begin
    valid_d     = valid_q;
    rs_addr_d   = rs_addr_q;
    rt_addr_d   = rt_addr_q;
    rs_val_d    = rs_val_q;
    rt_val_d    = rt_val_q;
    imm_d       = imm_q;
    shamt_d     = shamt_q;
    use_imm_d   = use_imm_q;
    use_shamt_d = use_shamt_q;
    ctrl_d      = ctrl_q;
    dest_d      = dest_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    if (load_bubble) begin
      valid_d     = 1'b0;
      rs_addr_d   = '0;
      rt_addr_d   = '0;
      rs_val_d    = '0;
      rt_val_d    = '0;
      imm_d       = '0;
      shamt_d     = '0;
      use_imm_d   = 1'b0;
      use_shamt_d = 1'b0;
      ctrl_d      = aluDisabled;
      dest_d      = '0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
    end else if (hold) begin
      rs_val_d = rs_fwd;
      rt_val_d = rt_fwd;
    end else begin
      valid_d     = 1'b1;
      rs_addr_d   = id_rs_addr;
      rt_addr_d   = id_rt_addr;
      rs_val_d    = rs_fwd;
      rt_val_d    = rt_fwd;
      imm_d       = id_imm32;
      shamt_d     = id_shamt;
      use_imm_d   = id_use_imm;
      use_shamt_d = id_use_shamt;
      ctrl_d      = id_alu_ctrl;
      dest_d      = id_dest_addr;
      reg_write_d = id_reg_write;
      mem_read_d  = id_mem_read;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q     <= 1'b0;
      rs_addr_q   <= '0;
      rt_addr_q   <= '0;
      rs_val_q    <= '0;
      rt_val_q    <= '0;
      imm_q       <= '0;
      shamt_q     <= '0;
      use_imm_q   <= 1'b0;
      use_shamt_q <= 1'b0;
      ctrl_q      <= aluDisabled;
      dest_q      <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      rs_addr_q   <= rs_addr_d;
      rt_addr_q   <= rt_addr_d;
      rs_val_q    <= rs_val_d;
      rt_val_q    <= rt_val_d;
      imm_q       <= imm_d;
      shamt_q     <= shamt_d;
      use_imm_q   <= use_imm_d;
      use_shamt_q <= use_shamt_d;
      ctrl_q      <= ctrl_d;
      dest_q      <= dest_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
    end
  end

  always_comb begin
    alu_a = rs_val_q;
    alu_b = rt_val_q;
    if (use_shamt_q) begin
      alu_a = rt_val_q;
      alu_b = {{(DATA_W-SHAMT_W){1'b0}}, shamt_q};
    end else if (use_imm_q) begin
      alu_b = imm_q;
    end
  end

  assign alu_ctrl      = ctrl_q;
  assign ex_valid      = valid_q;
  assign ex_dest_addr  = dest_q;
  assign ex_reg_write  = reg_write_q;
  assign ex_mem_read   = mem_read_q;
  assign ex_store_data = rt_val_q;

endmodule

// File: tb/tb_execute_issue_stage.sv
// Bench for execute_issue_stage: directed scenarios plus a randomized run against a reference model.
module tb_execute_issue_stage;
  import execute_issue_stage_pkg::*;

  localparam int EXP_W = 1 + 4 + 5 + 1 + 1 + 32 * 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [4:0]  id_rs_addr, id_rt_addr;
  logic        id_rs_used, id_rt_used;
  logic [31:0] id_rs_data, id_rt_data, id_imm32;
  logic [4:0]  id_shamt;
  logic        id_use_imm, id_use_shamt;
  logic [3:0]  id_alu_ctrl;
  logic [4:0]  id_dest_addr;
  logic        id_reg_write, id_mem_read;
  logic        hold, flush;
  logic        mem_reg_write, wb_reg_write;
  logic [4:0]  mem_dest_addr, wb_dest_addr;
  logic [31:0] mem_result, wb_result;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [3:0]  alu_ctrl;
  logic        ex_valid, ex_reg_write, ex_mem_read, hazard_stall;
  logic [4:0]  ex_dest_addr;

  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];

  // Reference model: the instruction sitting in EX, described by its operand values.
  logic        m_valid;
  logic [4:0]  m_rs_addr, m_rt_addr, m_shamt, m_dest;
  logic [31:0] m_rs, m_rt, m_imm;
  logic        m_use_imm, m_use_shamt, m_rw, m_mr;
  logic [3:0]  m_ctrl;

  execute_issue_stage dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr),
    .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .id_imm32(id_imm32), .id_shamt(id_shamt),
    .id_use_imm(id_use_imm), .id_use_shamt(id_use_shamt),
    .id_alu_ctrl(id_alu_ctrl), .id_dest_addr(id_dest_addr),
    .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
    .hold(hold), .flush(flush),
    .mem_reg_write(mem_reg_write), .mem_dest_addr(mem_dest_addr), .mem_result(mem_result),
    .wb_reg_write(wb_reg_write), .wb_dest_addr(wb_dest_addr), .wb_result(wb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .ex_valid(ex_valid), .ex_dest_addr(ex_dest_addr),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_store_data(ex_store_data), .hazard_stall(hazard_stall)
  );

  // ---- clock / reset ----
  always #5 clk = ~clk;

  // ---- driver tasks ----
  task automatic clear_inputs();
    id_valid = 0; id_rs_addr = 0; id_rt_addr = 0; id_rs_used = 0; id_rt_used = 0;
    id_rs_data = 0; id_rt_data = 0; id_imm32 = 0; id_shamt = 0;
    id_use_imm = 0; id_use_shamt = 0; id_alu_ctrl = aluAdd; id_dest_addr = 0;
    id_reg_write = 0; id_mem_read = 0; hold = 0; flush = 0;
    mem_reg_write = 0; mem_dest_addr = 0; mem_result = 0;
    wb_reg_write = 0; wb_dest_addr = 0; wb_result = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---- reference model helpers ----
  function automatic logic [31:0] ref_fwd(input logic [4:0] addr, input logic [31:0] rf);
    if (addr == 0) return rf;
    if (mem_reg_write && mem_dest_addr == addr) return mem_result;
    if (wb_reg_write && wb_dest_addr == addr) return wb_result;
    return rf;
  endfunction

  function automatic logic [EXP_W-1:0] model_outputs();
    logic [31:0] a, b;
    if (!m_valid) return {1'b0, 4'(aluDisabled), 5'd0, 1'b0, 1'b0, 96'd0};
    a = m_use_shamt ? m_rt : m_rs;
    b = m_use_shamt ? {27'd0, m_shamt} : (m_use_imm ? m_imm : m_rt);
    return {1'b1, m_ctrl, m_dest, m_rw, m_mr, a, b, m_rt};
  endfunction

  function automatic logic model_hazard();
    logic uses;
    uses = (id_rs_used && id_rs_addr == m_dest) || (id_rt_used && id_rt_addr == m_dest);
    return !hold && !flush && m_valid && m_mr && m_dest != 0 && id_valid && uses;
  endfunction

  task automatic model_bubble();
    m_valid = 0; m_rs_addr = 0; m_rt_addr = 0; m_rs = 0; m_rt = 0; m_imm = 0;
    m_shamt = 0; m_use_imm = 0; m_use_shamt = 0; m_ctrl = aluDisabled;
    m_dest = 0; m_rw = 0; m_mr = 0;
  endtask

  // Applies one clock edge's worth of the priority rules to the model, using current inputs.
  task automatic model_advance(input logic haz);
    if (flush) model_bubble();
    else if (hold) begin
      m_rs = ref_fwd(m_rs_addr, m_rs);
      m_rt = ref_fwd(m_rt_addr, m_rt);
    end else if (haz || !id_valid) model_bubble();
    else begin
      m_valid = 1; m_rs_addr = id_rs_addr; m_rt_addr = id_rt_addr;
      m_rs = ref_fwd(id_rs_addr, id_rs_data); m_rt = ref_fwd(id_rt_addr, id_rt_data);
      m_imm = id_imm32; m_shamt = id_shamt; m_use_imm = id_use_imm;
      m_use_shamt = id_use_shamt; m_ctrl = id_alu_ctrl; m_dest = id_dest_addr;
      m_rw = id_reg_write; m_mr = id_mem_read;
    end
  endtask

  // ---- scenario tasks ----
  task automatic test_reset();
    clear_inputs();
    reset = 0;
    id_valid = 1; id_rs_addr = 1; id_rs_data = 32'h1234; id_rt_data = 32'h5678;
    id_dest_addr = 7; id_reg_write = 1; id_mem_read = 1;
    step(); step();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", ex_valid); end
    checks++; if (alu_ctrl !== 4'(aluDisabled)) begin errors++; $display("FAIL reset_ctrl got %h exp %h", alu_ctrl, 4'(aluDisabled)); end
    checks++; if (alu_a !== 32'd0) begin errors++; $display("FAIL reset_alu_a got %h exp 0", alu_a); end
    checks++; if (alu_b !== 32'd0) begin errors++; $display("FAIL reset_alu_b got %h exp 0", alu_b); end
    checks++; if ({ex_reg_write, ex_mem_read, ex_dest_addr, ex_store_data, hazard_stall} !== '0) begin
      errors++; $display("FAIL reset_ex_fields got rw=%0b mr=%0b dest=%0d st=%h hz=%0b exp all 0",
                         ex_reg_write, ex_mem_read, ex_dest_addr, ex_store_data, hazard_stall);
    end
    clear_inputs();
    reset = 1;
  endtask

  task automatic test_rtype();
    clear_inputs();
    id_valid = 1; id_rs_addr = 1; id_rs_data = 5; id_rt_addr = 2; id_rt_data = 7;
    id_rs_used = 1; id_rt_used = 1; id_alu_ctrl = aluAdd; id_dest_addr = 3; id_reg_write = 1;
    step();
    checks++; if (alu_a !== 32'd5) begin errors++; $display("FAIL rtype_alu_a got %h exp 5", alu_a); end
    checks++; if (alu_b !== 32'd7) begin errors++; $display("FAIL rtype_alu_b got %h exp 7", alu_b); end
    checks++; if (alu_ctrl !== 4'(aluAdd)) begin errors++; $display("FAIL rtype_ctrl got %h exp %h", alu_ctrl, 4'(aluAdd)); end
    checks++; if (ex_valid !== 1'b1 || ex_reg_write !== 1'b1 || ex_dest_addr !== 5'd3) begin
      errors++; $display("FAIL rtype_ex got v=%0b rw=%0b dest=%0d exp 1 1 3", ex_valid, ex_reg_write, ex_dest_addr);
    end
    checks++; if (ex_store_data !== 32'd7) begin errors++; $display("FAIL rtype_store got %h exp 7", ex_store_data); end
    clear_inputs();
    step();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL idle_bubble got %0b exp 0", ex_valid); end
  endtask

  task automatic test_forward_priority();
    clear_inputs();
    id_valid = 1; id_rs_addr = 3; id_rs_data = 1; id_rs_used = 1;
    id_rt_addr = 7; id_rt_data = 32'h77; id_rt_used = 1;
    mem_reg_write = 1; mem_dest_addr = 3; mem_result = 32'h10;
    wb_reg_write = 1; wb_dest_addr = 3; wb_result = 32'h20;
    step();
    checks++; if (alu_a !== 32'h10) begin errors++; $display("FAIL fwd_mem got %h exp 10", alu_a); end
    checks++; if (alu_b !== 32'h77) begin errors++; $display("FAIL fwd_rt_none got %h exp 77", alu_b); end
    mem_reg_write = 0;
    step();
    checks++; if (alu_a !== 32'h20) begin errors++; $display("FAIL fwd_wb got %h exp 20", alu_a); end
    mem_reg_write = 1; mem_dest_addr = 0; wb_dest_addr = 0; id_rs_addr = 0; id_rs_data = 0;
    step();
    checks++; if (alu_a !== 32'h0) begin errors++; $display("FAIL fwd_r0 got %h exp 0", alu_a); end
    clear_inputs();
  endtask

  task automatic test_load_use();
    clear_inputs();
    id_valid = 1; id_rs_addr = 1; id_rs_data = 32'h100; id_rs_used = 1; id_use_imm = 1;
    id_imm32 = 8; id_alu_ctrl = aluAdd; id_dest_addr = 4; id_reg_write = 1; id_mem_read = 1;
    step();
    clear_inputs();
    id_valid = 1; id_rs_addr = 4; id_rs_used = 1; id_rs_data = 0; id_rt_addr = 2;
    id_rt_data = 3; id_rt_used = 1; id_alu_ctrl = aluSub; id_dest_addr = 6; id_reg_write = 1;
    #1;
    checks++; if (hazard_stall !== 1'b1) begin errors++; $display("FAIL loaduse_stall got %0b exp 1", hazard_stall); end
    step();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL loaduse_bubble got %0b exp 0", ex_valid); end
    checks++; if (hazard_stall !== 1'b0) begin errors++; $display("FAIL loaduse_release got %0b exp 0", hazard_stall); end
    mem_reg_write = 1; mem_dest_addr = 4; mem_result = 32'hABC;
    step();
    checks++; if (ex_valid !== 1'b1 || alu_a !== 32'hABC || alu_ctrl !== 4'(aluSub)) begin
      errors++; $display("FAIL loaduse_issue got v=%0b a=%h ctrl=%h exp 1 abc %h", ex_valid, alu_a, alu_ctrl, 4'(aluSub));
    end
    clear_inputs();
  endtask

  task automatic test_hold_refresh();
    clear_inputs();
    id_valid = 1; id_rt_addr = 5; id_rt_data = 32'h11; id_rt_used = 1;
    id_alu_ctrl = aluOr; id_dest_addr = 9; id_reg_write = 1;
    wb_reg_write = 1; wb_dest_addr = 5; wb_result = 32'h99;
    step();
    checks++; if (alu_b !== 32'h99) begin errors++; $display("FAIL hold_capture got %h exp 99", alu_b); end
    hold = 1; wb_reg_write = 0; id_rt_data = 32'h55; id_rt_addr = 6; id_dest_addr = 2;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (alu_b !== 32'h99 || ex_valid !== 1'b1 || ex_dest_addr !== 5'd9) begin
        errors++; $display("FAIL hold_keep%0d got b=%h v=%0b dest=%0d exp 99 1 9", i, alu_b, ex_valid, ex_dest_addr);
      end
    end
  endtask

  task automatic test_flush_hold();
    hold = 1; flush = 1; id_valid = 1; id_reg_write = 1;
    step();
    checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0) begin
      errors++; $display("FAIL flush_hold got v=%0b rw=%0b exp 0 0", ex_valid, ex_reg_write);
    end
    checks++; if (alu_ctrl !== 4'(aluDisabled)) begin errors++; $display("FAIL flush_ctrl got %h exp %h", alu_ctrl, 4'(aluDisabled)); end
    clear_inputs();
  endtask

  task automatic test_shift();
    clear_inputs();
    id_valid = 1; id_use_shamt = 1; id_use_imm = 1; id_imm32 = 32'h1234;
    id_rt_addr = 2; id_rt_data = 1; id_rs_addr = 1; id_rs_data = 32'hDEAD;
    id_shamt = 4; id_alu_ctrl = aluShiftLeft; id_dest_addr = 8; id_reg_write = 1;
    step();
    checks++; if (alu_a !== 32'd1) begin errors++; $display("FAIL shift_a got %h exp 1", alu_a); end
    checks++; if (alu_b !== 32'd4) begin errors++; $display("FAIL shift_b got %h exp 4", alu_b); end
    checks++; if (alu_ctrl !== 4'(aluShiftLeft)) begin errors++; $display("FAIL shift_ctrl got %h exp %h", alu_ctrl, 4'(aluShiftLeft)); end
    clear_inputs();
  endtask

  task automatic test_random();
    logic exp_hz;
    logic [EXP_W-1:0] exp_v, got_v;
    clear_inputs();
    flush = 1;
    step();
    model_bubble();
    for (int n = 0; n < 400; n++) begin
      id_valid = ($urandom_range(0, 3) != 0);
      id_rs_addr = 5'($urandom_range(0, 3)); id_rt_addr = 5'($urandom_range(0, 3));
      id_rs_used = 1'($urandom_range(0, 1)); id_rt_used = 1'($urandom_range(0, 1));
      id_rs_data = $urandom; id_rt_data = $urandom; id_imm32 = $urandom;
      id_shamt = 5'($urandom_range(0, 31));
      id_use_imm = 1'($urandom_range(0, 1)); id_use_shamt = ($urandom_range(0, 3) == 0);
      id_alu_ctrl = 4'($urandom_range(0, 11)); id_dest_addr = 5'($urandom_range(0, 3));
      id_reg_write = 1'($urandom_range(0, 1)); id_mem_read = ($urandom_range(0, 2) == 0);
      hold = ($urandom_range(0, 7) == 0); flush = ($urandom_range(0, 9) == 0);
      mem_reg_write = 1'($urandom_range(0, 1)); mem_dest_addr = 5'($urandom_range(0, 3));
      mem_result = $urandom;
      wb_reg_write = 1'($urandom_range(0, 1)); wb_dest_addr = 5'($urandom_range(0, 3));
      wb_result = $urandom;
      #1;
      exp_hz = model_hazard();
      checks++; if (hazard_stall !== exp_hz) begin
        errors++; $display("FAIL rand_hazard[%0d] got %0b exp %0b", n, hazard_stall, exp_hz);
      end
      model_advance(exp_hz);
      exp_q.push_back(model_outputs());
      step();
      exp_v = exp_q.pop_front();
      got_v = {ex_valid, alu_ctrl, ex_dest_addr, ex_reg_write, ex_mem_read, alu_a, alu_b, ex_store_data};
      checks++; if (got_v !== exp_v) begin
        errors++; $display("FAIL rand_outputs[%0d] got %h exp %h", n, got_v, exp_v);
      end
    end
    clear_inputs();
  endtask

  // ---- sequence and final report ----
  initial begin
    reset = 0;
    clear_inputs();
    #2;
    test_reset();
    test_rtype();
    test_forward_priority();
    test_load_use();
    test_hold_refresh();
    test_flush_hold();
    test_shift();
    test_random();
    if (exp_q.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain got %0d left exp 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
